// File: rtl/regfile_wb_arbiter_if.sv
// Register file write-port bundle: pipeline writeback, MDU result handshake,
// the arbitrated write port, and the decode bypass / pending-write signals.
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pipe_wen;
    logic [4:0]    pipe_wsel;
    logic [31:0]   pipe_wdat;
    logic          mdu_valid;
    logic          mdu_ready;
    logic [4:0]    mdu_wsel;
    logic [31:0]   mdu_wdat;
    logic          WEN;
    logic [4:0]    wsel;
    logic [31:0]   wdat;
    logic [4:0]    rsel1;
    logic [4:0]    rsel2;
    logic [31:0]   rf_rdat1;
    logic [31:0]   rf_rdat2;
    logic [31:0]   rdat1;
    logic [31:0]   rdat2;
    logic          pend1;
    logic          pend2;
    logic          wb_stall_req;
    logic [CW-1:0] fifo_count;

    modport master (
        output pipe_wen, pipe_wsel, pipe_wdat,
        output mdu_valid, mdu_wsel, mdu_wdat,
        output rsel1, rsel2, rf_rdat1, rf_rdat2,
        input  mdu_ready, WEN, wsel, wdat,
        input  rdat1, rdat2, pend1, pend2, wb_stall_req, fifo_count
    );

    modport slave (
        input  pipe_wen, pipe_wsel, pipe_wdat,
        input  mdu_valid, mdu_wsel, mdu_wdat,
        input  rsel1, rsel2, rf_rdat1, rf_rdat2,
        output mdu_ready, WEN, wsel, wdat,
        output rdat1, rdat2, pend1, pend2, wb_stall_req, fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: pipeline writeback has priority, MDU results
// queue in a small FIFO and drain into idle slots; also provides decode bypass.
module regfile_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input logic                CLK,
    input logic                RST,
    regfile_wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic [4:0]    ent_wsel_q [DEPTH];
    logic [4:0]    ent_wsel_d [DEPTH];
    logic [31:0]   ent_wdat_q [DEPTH];
    logic [31:0]   ent_wdat_d [DEPTH];

    logic p_act;
    logic push;
    logic pop;

    always_comb begin
        p_act         = bus.pipe_wen && (bus.pipe_wsel != 5'd0);
        bus.mdu_ready = !RST && (count_q < FULL);
        // A zero-destination MDU result completes the handshake but is never stored.
        push          = bus.mdu_valid && bus.mdu_ready && (bus.mdu_wsel != 5'd0);
        pop           = !RST && !p_act && (count_q != '0);
        bus.WEN       = !RST && (p_act || (count_q != '0));
        bus.wsel      = p_act ? bus.pipe_wsel : ent_wsel_q[rd_ptr_q];
        bus.wdat      = p_act ? bus.pipe_wdat : ent_wdat_q[rd_ptr_q];
    end

    always_comb begin
        bus.rdat1 = (bus.WEN && (bus.wsel == bus.rsel1) && (bus.rsel1 != 5'd0)) ? bus.wdat : bus.rf_rdat1;
        bus.rdat2 = (bus.WEN && (bus.wsel == bus.rsel2) && (bus.rsel2 != 5'd0)) ? bus.wdat : bus.rf_rdat2;
        bus.pend1 = 1'b0;
        bus.pend2 = 1'b0;
        // The entry draining this cycle still counts; bypass covers that read.
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((ent_wsel_q[rd_ptr_q + AW'(i)] == bus.rsel1) && (bus.rsel1 != 5'd0))
                    bus.pend1 = 1'b1;
                if ((ent_wsel_q[rd_ptr_q + AW'(i)] == bus.rsel2) && (bus.rsel2 != 5'd0))
                    bus.pend2 = 1'b1;
            end
        end
    end

    always_comb begin
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        ent_wsel_d = ent_wsel_q;
        ent_wdat_d = ent_wdat_q;
        if (push) begin
            ent_wsel_d[wr_ptr_q] = bus.mdu_wsel;
            ent_wdat_d[wr_ptr_q] = bus.mdu_wdat;
        end
        // With a non-empty FIFO and no pop, the pipeline must have taken the port.
        if (pop || (count_q == '0))
            starve_d = '0;
        else if (starve_q != SMAX)
            starve_d = starve_q + SW'(1);
        else
            starve_d = starve_q;
        if (pop)
            stall_d = 1'b0;
        else if (starve_d == SMAX)
            stall_d = 1'b1;
        else
            stall_d = stall_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge CLK) begin
        ent_wsel_q <= ent_wsel_d;
        ent_wdat_q <= ent_wdat_d;
    end

    assign bus.fifo_count   = count_q;
    assign bus.wb_stall_req = stall_q;
endmodule
